mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
Sequencer for the 2D systolic MAC array. On a start command it runs one tile:
- streams col kernel vectors from the local activation/weight SRAM into the array with inst_w=01 (kernel load);
- waits for the instruction wavefront to clear all rows;
- streams len activation vectors with inst_w=10 (execute);
- counts the valid output vectors leaving the bottom row, then reports done.

It sits between the top-level core FSM and the mac_array/L0 SRAM pair. It owns inst_w, the SRAM read enable and the SRAM read address.

Parameters:
row, 8, number of array rows (also the in_w lane count)
col, 8, number of array columns (kernel vectors per load)
addr_bw, 11, SRAM address width
len_bw, 11, width of the activation-vector count
drain_max, 32, DRAIN-state timeout in cycles

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
start  in  1  single-cycle tile request; sampled only in IDLE
abort  in  1  synchronous abort; highest priority
w_base  in  addr_bw  first kernel-vector address; latched on accepted start
x_base  in  addr_bw  first activation-vector address; latched on accepted start
len  in  len_bw  number of activation vectors; latched on accepted start
valid  in  col  valid vector from the mac_array bottom row
mem_rd_en  out  1  SRAM read enable; SRAM has 1-cycle read latency
mem_addr  out  addr_bw  SRAM read address
inst_w  out  2  array instruction: bit1 = execute, bit0 = kernel load
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at tile completion
err  out  1  sticky drain-timeout flag; cleared by the next accepted start
out_cnt  out  len_bw  output vectors observed in the current tile

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs and all counters go to 0.
- States and transitions:
  - IDLE: start=1 latches w_base, x_base and len, clears err and out_cnt.
    - If len==0, next state is DONE.
    - Otherwise next state is KLOAD.
  - KLOAD, exactly col cycles. mem_rd_en=1 each cycle. mem_addr = w_base+k for k = 0..col-1. Next state is KGAP.
  - KGAP, exactly row+1 cycles. mem_rd_en=0. Covers the 1-cycle SRAM latency plus the row-deep inst_w shift inside the array. Next state is EXEC.
  - EXEC, exactly len cycles. mem_rd_en=1. mem_addr = x_base+j for j = 0..len-1. Next state is DRAIN.
  - DRAIN: mem_rd_en=0.
    - If out_cnt==len, next state is DONE.
    - If the DRAIN cycle count reaches drain_max, set err=1 and go to DONE.
  - DONE, 1 cycle. done=1. Next state is IDLE.
- inst_w is registered and delayed exactly one cycle from mem_rd_en, so it aligns with SRAM read data on in_w.
  - inst_w=01 in the cycle after each KLOAD read.
  - inst_w=10 in the cycle after each EXEC read.
  - inst_w=00 otherwise.
  - inst_w is never 11.
- out_cnt increments on every cycle with valid[col-1]=1, in any non-IDLE state. It saturates at len.
- Address arithmetic is modulo 2^addr_bw; wrap past the top address is legal and silent.
- abort=1 in any state: next state is IDLE, mem_rd_en=0, inst_w=00 in the next cycle, no done pulse. abort wins over a simultaneous start.
- start while busy is ignored; latched values do not change.
- Latency for len=N, start sampled at edge 0:
  - KLOAD reads on cycles 1..col.
  - EXEC reads on cycles col+row+2 .. col+row+N+1.
  - done no earlier than the cycle after out_cnt reaches N.

Decomposition:
- Package mac_ctrl_pkg holds:
  - state_t enum: IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE;
  - inst encodings INST_NOP=2'b00, INST_KLOAD=2'b01, INST_EXEC=2'b10.
- One sub-module: mac_ctrl_addr_gen. It is a loadable base+offset counter producing mem_addr and the phase-end flag. It is instantiated once and reloaded with w_base in KLOAD and x_base in EXEC.

Test Plan:
- Basic tile, row=col=8, w_base=0x010, x_base=0x100, len=4, valid[7] pulsed 4 times during DRAIN:
  - mem_addr 0x010..0x017 on cycles 1..8;
  - inst_w=01 on cycles 2..9;
  - no reads on cycles 9..17;
  - mem_addr 0x100..0x103 on cycles 18..21;
  - inst_w=10 on cycles 19..22;
  - one done pulse after the 4th valid; out_cnt=4.
- len=0: start -> busy for 1 cycle, done pulse, mem_rd_en never asserted, inst_w stays 00.
- Timeout: len=3 with valid held at 0 -> err=1 after 32 DRAIN cycles, then done. The next start clears err.
- Abort mid-EXEC, asserted on cycle 19 -> cycle 20 has mem_rd_en=0 and inst_w=00, state IDLE, no done. A following start runs a full, correct tile.
- Start while busy, plus wrap: a second start pulsed during KGAP is ignored (addresses unchanged). x_base=0x7FE, len=4 -> EXEC addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Async reset asserted mid-KLOAD, between clock edges -> all outputs read 0 immediately. After release, the block stays in IDLE until the next start.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mac_ctrl_pkg
// Shared types and encodings for the systolic MAC array sequencer.
//   state_t    : sequencer states
//   INST_*     : array instruction encodings driven on inst_w
// ---------------------------------------------------------------------------
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        KGAP  = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] INST_NOP   = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/mac_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// mac_ctrl_addr_gen
// Loadable base+offset address counter for one SRAM read phase.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   load   in   capture base as the first address and limit as phase length
//   base   in   first address of the phase
//   limit  in   number of reads in the phase (must be >= 1 when used)
//   step   in   advance to the next address
//   addr   out  current read address (wraps modulo 2^addr_bw)
//   last   out  current address is the final read of the phase
// ---------------------------------------------------------------------------
module mac_ctrl_addr_gen #(
    parameter int addr_bw = 11,
    parameter int len_bw  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [addr_bw-1:0] base,
    input  logic [len_bw-1:0]  limit,
    input  logic               step,
    output logic [addr_bw-1:0] addr,
    output logic               last
);

    logic [addr_bw-1:0] addr_q;
    logic [len_bw-1:0]  off_q;
    logic [len_bw-1:0]  lim_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            off_q  <= '0;
            lim_q  <= '0;
        end else if (load) begin
            addr_q <= base;
            off_q  <= '0;
            lim_q  <= limit;
        end else if (step) begin
            // Address overflow wraps silently; the offset tracks phase length.
            addr_q <= addr_q + addr_bw'(1);
            off_q  <= off_q + len_bw'(1);
        end
    end

    assign addr = addr_q;
    assign last = (off_q == (lim_q - len_bw'(1)));

endmodule

// File: rtl/mac_array_ctrl.sv
// ---------------------------------------------------------------------------
// mac_array_ctrl
// Tile sequencer for the 2D systolic MAC array: kernel load, wavefront gap,
// activation execute, output drain, completion report.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   single-cycle tile request, honoured only in IDLE
//   abort      in   synchronous abort, overrides everything
//   w_base     in   first kernel-vector address
//   x_base     in   first activation-vector address
//   len        in   number of activation vectors
//   valid      in   per-column valid from the array bottom row
//   mem_rd_en  out  SRAM read enable (1-cycle read latency)
//   mem_addr   out  SRAM read address
//   inst_w     out  array instruction, aligned with SRAM read data
//   busy       out  sequencer not idle
//   done       out  one-cycle tile completion pulse
//   err        out  sticky drain-timeout flag
//   out_cnt    out  output vectors observed in the current tile
// ---------------------------------------------------------------------------
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int addr_bw   = 11,
    parameter int len_bw    = 11,
    parameter int drain_max = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [len_bw-1:0]  len,
    input  logic [col-1:0]     valid,
    output logic               mem_rd_en,
    output logic [addr_bw-1:0] mem_addr,
    output logic [1:0]         inst_w,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [len_bw-1:0]  out_cnt
);

    // Shared phase counter covers both the KGAP length and the DRAIN timeout.
    localparam int CNT_W = $clog2(drain_max + row + 1) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   phase_cnt_q;
    logic [len_bw-1:0]  len_q;
    logic [addr_bw-1:0] x_base_q;
    logic [len_bw-1:0]  out_cnt_q;
    logic               err_q;
    logic [1:0]         inst_w_p1;

    logic               start_acc;
    logic               err_set;
    logic               rd_en;
    logic [1:0]         inst_d;
    logic               ag_load;
    logic               ag_step;
    logic [addr_bw-1:0] ag_base;
    logic [len_bw-1:0]  ag_limit;
    logic               ag_last;

    // Only the last column marks a complete output vector.
    logic unused_valid_bits;
    assign unused_valid_bits = ^valid;

    mac_ctrl_addr_gen #(
        .addr_bw (addr_bw),
        .len_bw  (len_bw)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (ag_load),
        .base  (ag_base),
        .limit (ag_limit),
        .step  (ag_step),
        .addr  (mem_addr),
        .last  (ag_last)
    );

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        err_set   = 1'b0;
        rd_en     = 1'b0;
        inst_d    = INST_NOP;
        ag_load   = 1'b0;
        ag_step   = 1'b0;
        ag_base   = w_base;
        ag_limit  = len_bw'(col);

        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = KLOAD;
                        ag_load = 1'b1;
                    end
                end
            end
            KLOAD: begin
                rd_en   = 1'b1;
                ag_step = 1'b1;
                inst_d  = INST_KLOAD;
                if (ag_last) state_d = KGAP;
            end
            KGAP: begin
                // row+1 cycles: one for SRAM latency, row for the inst_w shift.
                if (phase_cnt_q == CNT_W'(row)) begin
                    state_d  = EXEC;
                    ag_load  = 1'b1;
                    ag_base  = x_base_q;
                    ag_limit = len_q;
                end
            end
            EXEC: begin
                rd_en   = 1'b1;
                ag_step = 1'b1;
                inst_d  = INST_EXEC;
                if (ag_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_cnt_q == len_q) begin
                    state_d = DONE;
                end else if (phase_cnt_q == CNT_W'(drain_max - 1)) begin
                    err_set = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort also squashes the instruction that would follow this cycle's read.
        if (abort) begin
            state_d   = IDLE;
            start_acc = 1'b0;
            err_set   = 1'b0;
            ag_load   = 1'b0;
            ag_step   = 1'b0;
            inst_d    = INST_NOP;
        end
    end

    // ---- stage p0 -> p1: state, counters, latched tile parameters ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_cnt_q <= '0;
            len_q       <= '0;
            x_base_q    <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            inst_w_p1   <= INST_NOP;
        end else begin
            state_q   <= state_d;
            inst_w_p1 <= inst_d;

            if (state_d != state_q) begin
                phase_cnt_q <= '0;
            end else if (state_q != IDLE) begin
                phase_cnt_q <= phase_cnt_q + CNT_W'(1);
            end

            if (start_acc) begin
                len_q    <= len;
                x_base_q <= x_base;
            end

            if (start_acc) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end

            if (start_acc) begin
                out_cnt_q <= '0;
            end else if ((state_q != IDLE) && valid[col-1] && (out_cnt_q < len_q)) begin
                out_cnt_q <= out_cnt_q + len_bw'(1);
            end
        end
    end

    assign mem_rd_en = rd_en;
    assign inst_w    = inst_w_p1;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_array_ctrl
// Scoreboard bench for mac_array_ctrl: directed tiles push expected SRAM
// reads, instructions and done events (with their cycle) into queues; a
// monitor pops and compares whenever the DUT presents one of them.
// ---------------------------------------------------------------------------
module tb_mac_array_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [10:0] w_base;
    logic [10:0] x_base;
    logic [10:0] len;
    logic [7:0]  valid;
    logic        mem_rd_en;
    logic [10:0] mem_addr;
    logic [1:0]  inst_w;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] out_cnt;

    typedef struct {
        int          cyc;
        logic [10:0] val;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [10:0] cnt;
        logic        err;
    } done_t;

    ev_t   exp_rd[$];
    ev_t   exp_inst[$];
    done_t exp_done[$];

    int edge_n = 0;
    int n_vec  = 0;
    int n_miss = 0;

    mac_array_ctrl #(
        .row       (8),
        .col       (8),
        .addr_bw   (11),
        .len_bw    (11),
        .drain_max (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .w_base    (w_base),
        .x_base    (x_base),
        .len       (len),
        .valid     (valid),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .inst_w    (inst_w),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_cnt   (out_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, req, edge_n);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: unexpected event with value 0x%0h, none required (edge %0d)", name, act, edge_n);
    endfunction

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        ev_t   e;
        done_t d;
        if (reset) begin
            if (mem_rd_en) begin
                if (exp_rd.size() == 0) unexpected("rd", 32'(mem_addr));
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_cycle", edge_n, e.cyc);
                    chk("rd_addr", 32'(mem_addr), 32'(e.val));
                end
            end
            if (inst_w != 2'b00) begin
                if (exp_inst.size() == 0) unexpected("inst_w", 32'(inst_w));
                else begin
                    e = exp_inst.pop_front();
                    chk("inst_cycle", edge_n, e.cyc);
                    chk("inst_w", 32'(inst_w), 32'(e.val));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) unexpected("done", 32'(out_cnt));
                else begin
                    d = exp_done.pop_front();
                    chk("done_cycle", edge_n, d.cyc);
                    chk("done_out_cnt", 32'(out_cnt), 32'(d.cnt));
                    chk("done_err", 32'(err), 32'(d.err));
                end
            end
        end
    end

    // Cycle c of a tile (c=1 is the first cycle after start is sampled)
    // is observed at the falling edge where edge_n == base + c - 1.
    task automatic wait_cyc(input int base, input int c);
        while (edge_n < base + c - 1) @(negedge clk);
    endtask

    task automatic start_tile(input logic [10:0] wb, input logic [10:0] xb,
                              input logic [10:0] ln, output int base);
        base   = edge_n + 1;
        w_base = wb;
        x_base = xb;
        len    = ln;
        start  = 1'b1;
    endtask

    task automatic push_kload(input int base, input logic [10:0] wb);
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back('{base + k, wb + 11'(k)});
            exp_inst.push_back('{base + 1 + k, 11'h001});
        end
    endtask

    task automatic push_exec(input int base, input logic [10:0] xb, input int nrd, input int ninst);
        for (int j = 0; j < nrd; j++) exp_rd.push_back('{base + 17 + j, xb + 11'(j)});
        for (int j = 0; j < ninst; j++) exp_inst.push_back('{base + 18 + j, 11'h002});
    endtask

    task automatic push_done(input int base, input int c, input logic [10:0] cnt, input logic e);
        exp_done.push_back('{base + c - 1, cnt, e});
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_inst_left"}, exp_inst.size(), 0);
        chk({tag, "_done_left"}, exp_done.size(), 0);
        exp_rd.delete();
        exp_inst.delete();
        exp_done.delete();
    endtask

    // Basic tile, len=4, four single valid pulses in DRAIN.
    task automatic run_basic(input logic [10:0] wb, input logic [10:0] xb);
        int base;
        @(negedge clk);
        start_tile(wb, xb, 11'd4, base);
        push_kload(base, wb);
        push_exec(base, xb, 4, 4);
        push_done(base, 31, 11'd4, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("basic_busy", 32'(busy), 1);
        // Lower-column valids must not count.
        wait_cyc(base, 10); valid = 8'h7F;
        wait_cyc(base, 13); valid = 8'h00;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(base, 23 + 2 * i); valid = 8'h80;
            wait_cyc(base, 24 + 2 * i); valid = 8'h00;
        end
        wait_cyc(base, 33);
        chk("basic_idle_busy", 32'(busy), 0);
        chk("basic_out_cnt", 32'(out_cnt), 4);
        check_empty("basic");
    endtask

    task automatic run_len0();
        int base;
        @(negedge clk);
        start_tile(11'h000, 11'h000, 11'd0, base);
        push_done(base, 1, 11'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("len0_busy", 32'(busy), 1);
        wait_cyc(base, 2);
        chk("len0_idle", 32'(busy), 0);
        chk("len0_err_clr", 32'(err), 0);
        check_empty("len0");
    endtask

    initial begin
        int base;
        reset  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        w_base = '0;
        x_base = '0;
        len    = '0;
        valid  = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_inst", 32'(inst_w), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_cnt", 32'(out_cnt), 0);
        reset = 1'b1;
        @(negedge clk);

        run_basic(11'h010, 11'h100);

        // Abort in EXEC cycle 19: cycle 20 idle, no read, no instruction, no done.
        @(negedge clk);
        start_tile(11'h040, 11'h300, 11'd4, base);
        push_kload(base, 11'h040);
        push_exec(base, 11'h300, 2, 1);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(base, 19); abort = 1'b1;
        wait_cyc(base, 20); abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rd_en", 32'(mem_rd_en), 0);
        chk("abort_inst", 32'(inst_w), 0);
        wait_cyc(base, 60);
        check_empty("abort");

        run_basic(11'h018, 11'h108);

        // Start during KGAP ignored; addresses wrap; out_cnt saturates.
        @(negedge clk);
        start_tile(11'h7FC, 11'h7FE, 11'd4, base);
        push_kload(base, 11'h7FC);
        push_exec(base, 11'h7FE, 4, 4);
        push_done(base, 25, 11'd4, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(base, 12);
        start = 1'b1; w_base = 11'h111; x_base = 11'h222; len = 11'd7;
        wait_cyc(base, 13); start = 1'b0;
        wait_cyc(base, 20); valid = 8'h80;
        wait_cyc(base, 28); valid = 8'h00;
        chk("wrap_out_cnt_sat", 32'(out_cnt), 4);
        chk("wrap_idle", 32'(busy), 0);
        check_empty("wrap");

        // Drain timeout: no valids, err after 32 DRAIN cycles.
        @(negedge clk);
        start_tile(11'h020, 11'h200, 11'd3, base);
        push_kload(base, 11'h020);
        push_exec(base, 11'h200, 3, 3);
        push_done(base, 53, 11'd0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(base, 55);
        chk("timeout_err_sticky", 32'(err), 1);
        chk("timeout_idle", 32'(busy), 0);
        check_empty("timeout");

        // Next start clears err.
        run_len0();

        // Async reset mid-KLOAD, between edges.
        @(negedge clk);
        start_tile(11'h050, 11'h500, 11'd2, base);
        for (int k = 0; k < 4; k++) exp_rd.push_back('{base + k, 11'h050 + 11'(k)});
        for (int k = 1; k < 4; k++) exp_inst.push_back('{base + k, 11'h001});
        @(negedge clk);
        start = 1'b0;
        wait_cyc(base, 4);
        #2 reset = 1'b0;
        #1;
        chk("arst_rd_en", 32'(mem_rd_en), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_inst", 32'(inst_w), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_out_cnt", 32'(out_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_stay_idle", 32'(busy), 0);
        check_empty("arst");

        run_len0();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
